// File: rtl/multicycle_ctrl_if.sv
// Control-unit <-> datapath/memory bundle.
//   master : the control FSM (drives enables/selects, samples IR, flags, mem_ready)
//   slave  : the datapath/memory side (drives IR, flags, mem_ready)
interface multicycle_ctrl_if #(
  parameter int INSTR_WIDTH  = 16,
  parameter int ALU_OP_WIDTH = 3
);
  // datapath -> control
  logic [INSTR_WIDTH-1:0]  instr;
  logic                    flag_z, flag_n, flag_c, flag_v;
  logic                    mem_ready;
  // control -> datapath
  logic                    mem_req, mem_we, mem_addr_sel;
  logic                    ir_we, pc_we;
  logic [1:0]              pc_sel;
  logic                    rf_we;
  logic [1:0]              rf_wsel;
  logic                    rf_link;
  logic                    alu_src_imm;
  logic [ALU_OP_WIDTH-1:0] alu_op;
  logic                    retire, halted, illegal;

  modport master (
    input  instr, flag_z, flag_n, flag_c, flag_v, mem_ready,
    output mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           rf_we, rf_wsel, rf_link, alu_src_imm, alu_op,
           retire, halted, illegal
  );

  modport slave (
    output instr, flag_z, flag_n, flag_c, flag_v, mem_ready,
    input  mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_sel,
           rf_we, rf_wsel, rf_link, alu_src_imm, alu_op,
           retire, halted, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit CPU.
// Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and decodes the
// datapath enables/selects from the current state. Memory accesses wait on
// mem_ready with no timeout. HALT and TRAP are terminal until reset.
// Ports:
//   clk    : clock
//   resetn : synchronous active-low reset (forces FETCH, clears illegal)
//   bus    : multicycle_ctrl_if.master (IR, flags, memory handshake, enables)
module multicycle_ctrl #(
  parameter int INSTR_WIDTH    = 16,
  parameter int OPC_WIDTH      = 4,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int ALU_OP_WIDTH   = 3
) (
  input  logic                 clk,
  input  logic                 resetn,
  multicycle_ctrl_if.master    bus
);

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE,
    S_WB_LI,
    S_EXEC_ADDI, S_WB_ADDI,
    S_EXEC_LW, S_MEM_LW, S_WB_LW,
    S_EXEC_SW, S_MEM_SW,
    S_EXEC_ALU, S_WB_ALU,
    S_EXEC_LINK, S_EXEC_JMP, S_EXEC_JPR, S_EXEC_BRH,
    S_HALT, S_TRAP
  } state_t;

  localparam logic [OPC_WIDTH-1:0] OP_LI   = OPC_WIDTH'(0);
  localparam logic [OPC_WIDTH-1:0] OP_ADDI = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OP_LW   = OPC_WIDTH'(2);
  localparam logic [OPC_WIDTH-1:0] OP_SW   = OPC_WIDTH'(3);
  localparam logic [OPC_WIDTH-1:0] OP_ALU  = OPC_WIDTH'(4);
  localparam logic [OPC_WIDTH-1:0] OP_JAL  = OPC_WIDTH'(5);
  localparam logic [OPC_WIDTH-1:0] OP_JMP  = OPC_WIDTH'(6);
  localparam logic [OPC_WIDTH-1:0] OP_JPR  = OPC_WIDTH'(7);
  localparam logic [OPC_WIDTH-1:0] OP_BRH  = OPC_WIDTH'(8);
  localparam logic [OPC_WIDTH-1:0] OP_HALT = {OPC_WIDTH{1'b1}};

  state_t                  state;
  logic                    illegal_q;
  logic [OPC_WIDTH-1:0]    opc;
  logic [2:0]              cond;
  logic [ALU_OP_WIDTH-1:0] func;
  logic                    taken;

  assign opc  = bus.instr[INSTR_WIDTH-1 -: OPC_WIDTH];
  assign cond = bus.instr[INSTR_WIDTH-OPC_WIDTH-1 -: 3];
  assign func = bus.instr[ALU_OP_WIDTH-1:0];

  // Remaining IR bits are operands for the datapath, not the controller.
  logic unused_ok;
  assign unused_ok = ^{bus.instr, REG_ADDR_WIDTH[0]};

  always_comb begin
    case (cond)
      3'd0:    taken = 1'b1;
      3'd1:    taken = bus.flag_z;
      3'd2:    taken = ~bus.flag_z;
      3'd3:    taken = bus.flag_n;
      3'd4:    taken = ~bus.flag_n;
      3'd5:    taken = bus.flag_c;
      3'd6:    taken = bus.flag_v;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH:     if (bus.mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (opc)
            OP_LI:   state <= S_WB_LI;
            OP_ADDI: state <= S_EXEC_ADDI;
            OP_LW:   state <= S_EXEC_LW;
            OP_SW:   state <= S_EXEC_SW;
            OP_ALU:  state <= S_EXEC_ALU;
            OP_JAL:  state <= S_EXEC_LINK;
            OP_JMP:  state <= S_EXEC_JMP;
            OP_JPR:  state <= S_EXEC_JPR;
            OP_BRH:  state <= S_EXEC_BRH;
            OP_HALT: state <= S_HALT;
            default: begin
              state     <= S_TRAP;
              illegal_q <= 1'b1;
            end
          endcase
        end
        S_EXEC_ADDI: state <= S_WB_ADDI;
        S_EXEC_LW:   state <= S_MEM_LW;
        S_MEM_LW:    if (bus.mem_ready) state <= S_WB_LW;
        S_EXEC_SW:   state <= S_MEM_SW;
        S_MEM_SW:    if (bus.mem_ready) state <= S_FETCH;
        S_EXEC_ALU:  state <= S_WB_ALU;
        S_EXEC_LINK: state <= S_EXEC_JMP;
        S_HALT:      state <= S_HALT;
        S_TRAP:      state <= S_TRAP;
        default:     state <= S_FETCH;  // WB_*, JMP, JPR, BRH all retire here
      endcase
    end
  end

  // Outputs decode the current state; the few that depend on mem_ready,
  // flags or the opcode are qualified combinationally within that state.
  // Everything is forced low while resetn is asserted.
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.ir_we        = 1'b0;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = 2'd0;
    bus.rf_we        = 1'b0;
    bus.rf_wsel      = 2'd0;
    bus.rf_link      = 1'b0;
    bus.alu_src_imm  = 1'b0;
    bus.alu_op       = '0;
    bus.retire       = 1'b0;
    bus.halted       = 1'b0;
    bus.illegal      = resetn & illegal_q;
    if (resetn) begin
      case (state)
        S_FETCH: begin
          bus.mem_req = 1'b1;
          bus.ir_we   = bus.mem_ready;
          bus.pc_we   = bus.mem_ready;
        end
        S_DECODE:    bus.retire = (opc == OP_HALT);
        S_WB_LI: begin
          bus.rf_we   = 1'b1;
          bus.rf_wsel = 2'd2;
          bus.retire  = 1'b1;
        end
        S_EXEC_ADDI, S_EXEC_LW, S_EXEC_SW: bus.alu_src_imm = 1'b1;
        S_WB_ADDI: begin
          bus.rf_we       = 1'b1;
          bus.alu_src_imm = 1'b1;
          bus.retire      = 1'b1;
        end
        S_MEM_LW: begin
          bus.mem_req      = 1'b1;
          bus.mem_addr_sel = 1'b1;
        end
        S_WB_LW: begin
          bus.rf_we   = 1'b1;
          bus.rf_wsel = 2'd1;
          bus.retire  = 1'b1;
        end
        S_MEM_SW: begin
          bus.mem_req      = 1'b1;
          bus.mem_we       = 1'b1;
          bus.mem_addr_sel = 1'b1;
          bus.retire       = bus.mem_ready;
        end
        S_EXEC_ALU:  bus.alu_op = func;
        S_WB_ALU: begin
          bus.rf_we  = 1'b1;
          bus.alu_op = func;
          bus.retire = 1'b1;
        end
        S_EXEC_LINK: begin
          bus.rf_we   = 1'b1;
          bus.rf_wsel = 2'd3;
          bus.rf_link = 1'b1;
        end
        S_EXEC_JMP: begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = 2'd1;
          bus.retire = 1'b1;
        end
        S_EXEC_JPR: begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = 2'd2;
          bus.retire = 1'b1;
        end
        S_EXEC_BRH: begin
          bus.pc_we  = taken;
          bus.pc_sel = taken ? 2'd1 : 2'd0;
          bus.retire = 1'b1;
        end
        S_HALT, S_TRAP: bus.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: the stimulus side expands each
// instruction into its expected per-cycle output vectors and queues them;
// a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_ctrl;

  typedef logic [18:0] ovec_t;
  localparam ovec_t MREQ   = 19'd1 << 18;
  localparam ovec_t MWE    = 19'd1 << 17;
  localparam ovec_t MAS    = 19'd1 << 16;
  localparam ovec_t IRWE   = 19'd1 << 15;
  localparam ovec_t PCWE   = 19'd1 << 14;
  localparam ovec_t PCSEL1 = 19'd1 << 12;
  localparam ovec_t PCSEL2 = 19'd2 << 12;
  localparam ovec_t RFWE   = 19'd1 << 11;
  localparam ovec_t WSEL1  = 19'd1 << 9;
  localparam ovec_t WSEL2  = 19'd2 << 9;
  localparam ovec_t WSEL3  = 19'd3 << 9;
  localparam ovec_t LINK   = 19'd1 << 8;
  localparam ovec_t ASI    = 19'd1 << 7;
  localparam ovec_t RET    = 19'd1 << 3;
  localparam ovec_t HALTED = 19'd1 << 2;
  localparam ovec_t ILL    = 19'd1 << 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.INSTR_WIDTH(16), .ALU_OP_WIDTH(3)) bus();

  multicycle_ctrl #(
    .INSTR_WIDTH(16), .OPC_WIDTH(4), .REG_ADDR_WIDTH(3), .ALU_OP_WIDTH(3)
  ) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  ovec_t exp_q[$];
  string tag_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc_n = 0;

  ovec_t act;
  assign act = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, bus.ir_we, bus.pc_we,
                bus.pc_sel, bus.rf_we, bus.rf_wsel, bus.rf_link, bus.alu_src_imm,
                bus.alu_op, bus.retire, bus.halted, bus.illegal, 1'b0};

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ovec_t e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_cmp++;
      if (act !== e) begin
        n_bad++;
        $display("FAIL %s (cycle %0d): got %05h expected %05h", t, cyc_n, act, e);
      end
    end
  end

  function automatic ovec_t aluop(input logic [2:0] f);
    return ovec_t'(f) << 4;
  endfunction

  // Branch rule: cond -> taken, from flags {z,n,c,v}.
  function automatic logic br_taken(input logic [2:0] c, input logic [3:0] fl);
    case (c)
      3'd0: return 1'b1;
      3'd1: return fl[3];
      3'd2: return !fl[3];
      3'd3: return fl[2];
      3'd4: return !fl[2];
      3'd5: return fl[1];
      3'd6: return fl[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Apply one cycle of inputs and queue the outputs expected during it.
  task automatic cyc(input logic rn, input logic mr, input logic [15:0] ins,
                     input logic [3:0] fl, input ovec_t e, input string tag);
    resetn        = rn;
    bus.mem_ready = mr;
    bus.instr     = ins;
    {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = fl;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic rst_cyc();
    cyc(1'b0, rbit(), 16'($urandom), 4'($urandom), '0, "reset");
  endtask

  // Plain cycle with don't-care inputs (mem_ready randomised: it must be ignored).
  task automatic pc(input logic [15:0] ins, input ovec_t e, input string tag);
    cyc(1'b1, rbit(), ins, 4'($urandom), e, tag);
  endtask

  task automatic fetch(input int fw);
    for (int i = 0; i < fw; i++)
      cyc(1'b1, 1'b0, 16'($urandom), 4'($urandom), MREQ, "fetch_wait");
    cyc(1'b1, 1'b1, 16'($urandom), 4'($urandom), MREQ | IRWE | PCWE, "fetch_done");
  endtask

  // Reference sequence of one instruction from FETCH to its retire (or to
  // the reset that leaves HALT/TRAP).
  task automatic run_instr(input logic [15:0] ins, input int fw, input int mw,
                           input logic [3:0] brfl, input int post);
    logic [3:0] opc;
    logic [2:0] f;
    opc = ins[15:12];
    f   = ins[2:0];
    fetch(fw);
    pc(ins, (opc == 4'hF) ? RET : '0, "decode");
    case (opc)
      4'h0: pc(ins, RFWE | WSEL2 | RET, "wb_li");
      4'h1: begin
        pc(ins, ASI, "exec_addi");
        pc(ins, RFWE | ASI | RET, "wb_addi");
      end
      4'h2: begin
        pc(ins, ASI, "exec_lw");
        for (int i = 0; i < mw; i++)
          cyc(1'b1, 1'b0, ins, 4'($urandom), MREQ | MAS, "mem_lw_wait");
        cyc(1'b1, 1'b1, ins, 4'($urandom), MREQ | MAS, "mem_lw_done");
        pc(ins, RFWE | WSEL1 | RET, "wb_lw");
      end
      4'h3: begin
        pc(ins, ASI, "exec_sw");
        for (int i = 0; i < mw; i++)
          cyc(1'b1, 1'b0, ins, 4'($urandom), MREQ | MWE | MAS, "mem_sw_wait");
        cyc(1'b1, 1'b1, ins, 4'($urandom), MREQ | MWE | MAS | RET, "mem_sw_done");
      end
      4'h4: begin
        pc(ins, aluop(f), "exec_alu");
        pc(ins, RFWE | aluop(f) | RET, "wb_alu");
      end
      4'h5: begin
        pc(ins, RFWE | WSEL3 | LINK, "exec_link");
        pc(ins, PCWE | PCSEL1 | RET, "jal_jmp");
      end
      4'h6: pc(ins, PCWE | PCSEL1 | RET, "exec_jmp");
      4'h7: pc(ins, PCWE | PCSEL2 | RET, "exec_jpr");
      4'h8: cyc(1'b1, rbit(), ins, brfl,
                RET | (br_taken(ins[11:9], brfl) ? (PCWE | PCSEL1) : '0), "exec_brh");
      4'hF: begin
        for (int i = 0; i < post; i++) pc(16'($urandom), HALTED, "halt");
        rst_cyc();
      end
      default: begin
        for (int i = 0; i < post; i++) pc(16'($urandom), HALTED | ILL, "trap");
        rst_cyc();
      end
    endcase
  endtask

  initial begin
    bus.instr = '0;
    bus.mem_ready = 1'b0;
    {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} = 4'h0;
    @(posedge clk);
    #1;

    // Reset state.
    rst_cyc();
    rst_cyc();

    // Fetch with three wait states, then a zero-wait LW.
    run_instr(16'h0123, 3, 0, 4'h0, 0);
    run_instr(16'h2abc, 0, 0, 4'h0, 0);

    // Reset while MEM_LW waits: controller must restart at FETCH.
    fetch(1);
    pc(16'h2345, '0, "decode");
    pc(16'h2345, ASI, "exec_lw");
    cyc(1'b1, 1'b0, 16'h2345, 4'h0, MREQ | MAS, "mem_lw_wait");
    cyc(1'b0, 1'b0, 16'h2345, 4'h0, '0, "reset_in_mem");
    cyc(1'b1, 1'b0, 16'h0000, 4'h0, MREQ, "fetch_after_reset");
    cyc(1'b1, 1'b1, 16'h0000, 4'h0, MREQ | IRWE | PCWE, "fetch_done");
    pc(16'h6000, '0, "decode");
    pc(16'h6000, PCWE | PCSEL1 | RET, "exec_jmp");

    // Branch conditions: Z taken / not taken, never.
    run_instr(16'h8200, 0, 0, 4'b1000, 0);
    run_instr(16'h8200, 0, 0, 4'b0111, 0);
    run_instr(16'h8e00, 0, 0, 4'b1111, 0);

    // JAL, ALU, SW with waits.
    run_instr(16'h5123, 1, 0, 4'h0, 0);
    run_instr(16'h4005, 0, 0, 4'h0, 0);
    run_instr(16'h3111, 2, 3, 4'h0, 0);

    // Illegal opcode held for 10 cycles, then HALT.
    run_instr(16'ha000, 0, 0, 4'h0, 10);
    run_instr(16'hf000, 0, 0, 4'h0, 4);

    // Random instruction stream.
    for (int k = 0; k < 400; k++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      if ($urandom_range(0, 3) != 0) ins[15:12] = 4'($urandom_range(0, 8));
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3),
                4'($urandom), $urandom_range(1, 5));
    end

    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
